pe_v3_vec_mac: RTL and testbench
================================

PE_V3_VEC_MAC -- requirements
Module: pe_v3_vec_mac

Interface
REQ-001 Parameter REG_WIDTH, default 16: operand width of the a and b lanes, unsigned.
REQ-002 Parameter VECTOR, default 2: number of a/c lanes; the b operand is shared by all lanes; legal range 1..16.
REQ-003 Parameter ACC_WIDTH, default 32: width of c_in, c_out and the accumulators; shall be >= 2*REG_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ce  input  1  clock enable; 0 freezes every register in the block.
REQ-007 a_in  input  VECTOR x REG_WIDTH  per-lane multiplicand from the west neighbour.
REQ-008 b_in  input  REG_WIDTH  shared multiplier from the north neighbour.
REQ-009 c_in  input  VECTOR x ACC_WIDTH  per-lane partial sum from the upstream PE.
REQ-010 valid_in  input  1  a_in/b_in/c_in/flush carry a beat this cycle.
REQ-011 acc_mode  input  1  0 = systolic pass-through sum; 1 = local (output-stationary) accumulate.
REQ-012 flush  input  1  with valid_in and acc_mode=1: final beat of the accumulation; emit the result.
REQ-013 a_out  output  VECTOR x REG_WIDTH  a_in delayed one cycle.
REQ-014 b_out  output  REG_WIDTH  b_in delayed one cycle.
REQ-015 c_out  output  VECTOR x ACC_WIDTH  per-lane result.
REQ-016 valid_out  output  1  c_out holds a new result this cycle.
REQ-017 busy  output  1  high while the FSM is in ACCUM.

Function
REQ-018 Forwarding: when ce=1, a_out<=a_in and b_out<=b_in each cycle, independent of valid_in and mode.
REQ-019 Stage 1 (when ce=1): register p[i]=a_in[i]*b_in (full 2*REG_WIDTH, zero-extended to ACC_WIDTH), c_in, valid_in, acc_mode and flush.
REQ-020 Stage 2 (when ce=1) consumes the stage-1 registers; c_out/valid_out latency from an input beat is exactly 2 enabled cycles.
REQ-021 Pass mode (stage-1 mode=0, valid=1): c_out[i] <= p[i] + c_in[i]; valid_out <= 1; accumulators unchanged.
REQ-022 Accumulate mode (stage-1 mode=1, valid=1, flush=0): acc[i] <= acc[i] + p[i]; valid_out <= 0; c_in ignored.
REQ-023 Accumulate mode with flush=1: c_out[i] <= acc[i] + p[i]; valid_out <= 1; acc[i] <= 0 in the same edge.
REQ-024 Stage-1 valid=0: valid_out <= 0; c_out and acc hold their values.
REQ-025 All additions wrap modulo 2^ACC_WIDTH; no saturation and no overflow flag.
REQ-026 FSM states IDLE, ACCUM; IDLE->ACCUM on a stage-2 accumulate beat with flush=0; ACCUM->IDLE on a stage-2 accumulate beat with flush=1; IDLE stays IDLE on a flush beat (single-beat accumulation, result = p).
REQ-027 A pass-mode beat while in ACCUM is processed as pass mode; the state and acc are retained for later accumulate beats.
REQ-028 flush with acc_mode=0 or valid_in=0 has no effect.
REQ-029 ce=0: all registers including FSM, acc, and valid_out hold; valid_out therefore stays asserted if it was 1.
REQ-030 Multiplier and stage-2 adder are structured to map onto one DSP slice per lane (registered multiply, registered add).

Reset
REQ-031 rst=1 asynchronously clears a_out, b_out, c_out, acc, all stage-1 registers, valid_out and busy to 0 and forces the FSM to IDLE, regardless of ce.
REQ-032 Reset mid-accumulation discards partial sums; no result is emitted for the aborted accumulation.
REQ-033 First rising edge after rst falls behaves as normal operation; a beat presented on that edge is accepted.

Verification (REG_WIDTH=16, VECTOR=2, ACC_WIDTH=32)
REQ-034 Pass: a_in={3,5}, b_in=7, c_in={10,20}, valid_in=1, acc_mode=0 -> 2 cycles later c_out={31,55}, valid_out=1; a_out={3,5}, b_out=7 after 1 cycle.
REQ-035 Accumulate: 3 beats a={1,2},b={4,5,6} with flush on beat 3 -> busy high after beat 1; single valid_out pulse with c_out={15,30}; busy low after that edge; acc then 0.
REQ-036 Wrap: acc_mode=0, a={0xFFFF,0}, b=0xFFFF, c_in={0xFFFFFFFF,0} -> c_out={0xFFFE0000,0}.
REQ-037 Stall: ce=0 for 3 cycles between beats of REQ-035 -> identical c_out={15,30}, with output delayed by 3 cycles, and no extra valid_out pulse.
REQ-038 Reset abort: 2 accumulate beats, then rst pulse, then single flush beat a={2,2},b=3 -> c_out={6,6}, not including pre-reset sums.
REQ-039 Interleave: in ACCUM, insert one pass beat -> correct pass result emitted; subsequent flush returns the accumulate sum excluding the pass beat.

Source files
------------

// File: rtl/pe_v3_vec_mac_if.sv
// Bus bundle for the vector MAC processing element: systolic operands in,
// forwarded operands and per-lane results out.
interface pe_v3_vec_mac_if #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned VECTOR    = 2,
  parameter int unsigned ACC_WIDTH = 32
);
  logic                                ce;
  logic [VECTOR-1:0][REG_WIDTH-1:0]    a_in;
  logic [REG_WIDTH-1:0]                b_in;
  logic [VECTOR-1:0][ACC_WIDTH-1:0]    c_in;
  logic                                valid_in;
  logic                                acc_mode;
  logic                                flush;
  logic [VECTOR-1:0][REG_WIDTH-1:0]    a_out;
  logic [REG_WIDTH-1:0]                b_out;
  logic [VECTOR-1:0][ACC_WIDTH-1:0]    c_out;
  logic                                valid_out;
  logic                                busy;

  modport master (
    output ce, a_in, b_in, c_in, valid_in, acc_mode, flush,
    input  a_out, b_out, c_out, valid_out, busy
  );

  modport slave (
    input  ce, a_in, b_in, c_in, valid_in, acc_mode, flush,
    output a_out, b_out, c_out, valid_out, busy
  );
endinterface

// File: rtl/pe_v3_vec_mac.sv
// Vector multiply-accumulate PE: registered multiply stage, then a registered
// add stage that either passes a systolic sum through or accumulates locally.
module pe_v3_vec_mac #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned VECTOR    = 2,
  parameter int unsigned ACC_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  pe_v3_vec_mac_if.slave  bus
);

  localparam int unsigned PROD_WIDTH = 2 * REG_WIDTH;
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_ACCUM   = 1'b1;

  typedef logic [VECTOR-1:0][ACC_WIDTH-1:0] acc_vec_t;
  typedef logic [VECTOR-1:0][REG_WIDTH-1:0] reg_vec_t;

  reg_vec_t             a_out_q;
  logic [REG_WIDTH-1:0] b_out_q;

  acc_vec_t prod_d, prod_q;
  acc_vec_t c_in_q;
  logic     s1_valid_q, s1_mode_q, s1_flush_q;

  acc_vec_t   c_out_d, c_out_q;
  acc_vec_t   acc_d, acc_q;
  logic       valid_out_d, valid_out_q;
  logic [0:0] state_d, state_q;

  // Full-width unsigned product per lane, zero-extended into the accumulator width
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < VECTOR; i++) begin
      prod_d[i] = ACC_WIDTH'(PROD_WIDTH'(bus.a_in[i]) * PROD_WIDTH'(bus.b_in));
    end
  end

  // Stage 1: operand forwarding and multiplier output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out_q    <= '0;
      b_out_q    <= '0;
      prod_q     <= '0;
      c_in_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_flush_q <= 1'b0;
    end else if (bus.ce) begin
      a_out_q    <= bus.a_in;
      b_out_q    <= bus.b_in;
      prod_q     <= prod_d;
      c_in_q     <= bus.c_in;
      s1_valid_q <= bus.valid_in;
      s1_mode_q  <= bus.acc_mode;
      s1_flush_q <= bus.flush;
    end
  end

  // Stage 2 next-state: pass-through sum, accumulate, or flush-and-clear
  always_comb begin
    c_out_d     = c_out_q;
    acc_d       = acc_q;
    valid_out_d = 1'b0;
    state_d     = state_q;
    if (s1_valid_q) begin
      if (!s1_mode_q) begin
        for (int i = 0; i < VECTOR; i++) begin
          c_out_d[i] = c_in_q[i] + prod_q[i];
        end
        valid_out_d = 1'b1;
      end else if (s1_flush_q) begin
        for (int i = 0; i < VECTOR; i++) begin
          c_out_d[i] = acc_q[i] + prod_q[i];
        end
        acc_d       = '0;
        valid_out_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        for (int i = 0; i < VECTOR; i++) begin
          acc_d[i] = acc_q[i] + prod_q[i];
        end
        state_d = ST_ACCUM;
      end
    end
  end

  // Stage 2 registers and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_out_q     <= '0;
      acc_q       <= '0;
      valid_out_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else if (bus.ce) begin
      c_out_q     <= c_out_d;
      acc_q       <= acc_d;
      valid_out_q <= valid_out_d;
      state_q     <= state_d;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.c_out     = c_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy      = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_pe_v3_vec_mac.sv
// Directed bench for pe_v3_vec_mac at REG_WIDTH=16, VECTOR=2, ACC_WIDTH=32.
module tb_pe_v3_vec_mac;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pe_v3_vec_mac_if #(.REG_WIDTH(16), .VECTOR(2), .ACC_WIDTH(32)) bus ();

  pe_v3_vec_mac #(.REG_WIDTH(16), .VECTOR(2), .ACC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] b,
                        input logic [31:0] c0, input logic [31:0] c1,
                        input logic v, input logic m, input logic f);
    bus.a_in[0]  = a0;
    bus.a_in[1]  = a1;
    bus.b_in     = b;
    bus.c_in[0]  = c0;
    bus.c_in[1]  = c1;
    bus.valid_in = v;
    bus.acc_mode = m;
    bus.flush    = f;
  endtask

  task automatic idle();
    set_in(16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [1:0][31:0] exp_c;
    exp_c = '0;
    rst = 1'b1;
    bus.ce = 1'b1;
    idle();
    #1;
    total++;
    if (bus.c_out !== exp_c) begin bad++; $display("FAIL reset_c_out got=%h want=%h", bus.c_out, exp_c); end
    total++;
    if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_out); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.a_out !== 32'd0 || bus.b_out !== 16'd0) begin
      bad++; $display("FAIL reset_fwd got a=%h b=%h want 0", bus.a_out, bus.b_out);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_pass();
    logic [1:0][31:0] exp_c;
    exp_c[0] = 32'd31;
    exp_c[1] = 32'd55;
    set_in(16'd3, 16'd5, 16'd7, 32'd10, 32'd20, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    total++;
    if (bus.a_out[0] !== 16'd3 || bus.a_out[1] !== 16'd5 || bus.b_out !== 16'd7) begin
      bad++; $display("FAIL pass_fwd got a=%h b=%h want a={5,3} b=7", bus.a_out, bus.b_out);
    end
    total++;
    if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL pass_early_valid got=%b want=0", bus.valid_out); end
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL pass_result got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    tick();
    total++;
    if (bus.valid_out !== 1'b0 || bus.c_out !== exp_c) begin
      bad++; $display("FAIL pass_hold got c=%h v=%b want c=%h v=0", bus.c_out, bus.valid_out, exp_c);
    end
  endtask

  task automatic test_accum();
    logic [1:0][31:0] exp_c;
    int pulses;
    pulses = 0;
    exp_c[0] = 32'd15;
    exp_c[1] = 32'd30;
    set_in(16'd1, 16'd2, 16'd4, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    pulses += int'(bus.valid_out);
    set_in(16'd1, 16'd2, 16'd5, 32'd99, 32'd99, 1'b1, 1'b1, 1'b0);
    tick();
    pulses += int'(bus.valid_out);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL accum_busy got=%b want=1", bus.busy); end
    set_in(16'd1, 16'd2, 16'd6, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    pulses += int'(bus.valid_out);
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL accum_result got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL accum_busy_after got=%b want=0", bus.busy); end
    tick();
    pulses += int'(bus.valid_out);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL accum_extra_pulses got=%0d want=0", pulses); end
    // A single-beat flush now shows whether the accumulator was cleared
    exp_c[0] = 32'd2;
    exp_c[1] = 32'd2;
    set_in(16'd1, 16'd1, 16'd2, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL accum_cleared got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0][31:0] exp_c;
    exp_c[0] = 32'hFFFE0000;
    exp_c[1] = 32'h0;
    set_in(16'hFFFF, 16'h0, 16'hFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL wrap got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [1:0][31:0] exp_c;
    int pulses;
    pulses = 0;
    exp_c[0] = 32'd15;
    exp_c[1] = 32'd30;
    set_in(16'd1, 16'd2, 16'd4, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(16'd1, 16'd2, 16'd5, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ce = 1'b0;
    set_in(16'd9, 16'd9, 16'd9, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      pulses += int'(bus.valid_out);
    end
    total++;
    if (bus.busy !== 1'b1 || bus.a_out[0] !== 16'd1 || bus.b_out !== 16'd5) begin
      bad++; $display("FAIL stall_frozen got busy=%b a0=%h b=%h want busy=1 a0=1 b=5", bus.busy, bus.a_out[0], bus.b_out);
    end
    bus.ce = 1'b1;
    set_in(16'd1, 16'd2, 16'd6, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    pulses += int'(bus.valid_out);
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL stall_result got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL stall_extra_pulses got=%0d want=0", pulses); end
    // Freezing with valid_out high keeps it high
    bus.ce = 1'b0;
    tick();
    tick();
    total++;
    if (bus.valid_out !== 1'b1 || bus.c_out !== exp_c) begin
      bad++; $display("FAIL stall_hold_valid got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    bus.ce = 1'b1;
    tick();
    total++;
    if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL stall_release got v=%b want=0", bus.valid_out); end
  endtask

  task automatic test_reset_abort();
    logic [1:0][31:0] exp_c;
    exp_c = '0;
    set_in(16'd1, 16'd1, 16'd9, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    idle();
    tick();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b want=1", bus.busy); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0 || bus.c_out !== exp_c) begin
      bad++; $display("FAIL abort_async got busy=%b v=%b c=%h want 0", bus.busy, bus.valid_out, bus.c_out);
    end
    rst = 1'b0;
    exp_c[0] = 32'd6;
    exp_c[1] = 32'd6;
    set_in(16'd2, 16'd2, 16'd3, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL abort_result got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    tick();
  endtask

  task automatic test_interleave();
    logic [1:0][31:0] exp_c;
    set_in(16'd1, 16'd2, 16'd2, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(16'd3, 16'd4, 16'd10, 32'd100, 32'd200, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(16'd1, 16'd2, 16'd3, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    exp_c[0] = 32'd130;
    exp_c[1] = 32'd240;
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL interleave_pass got c=%h v=%b busy=%b want c=%h v=1 busy=1",
                      bus.c_out, bus.valid_out, bus.busy, exp_c);
    end
    tick();
    exp_c[0] = 32'd5;
    exp_c[1] = 32'd10;
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL interleave_flush got c=%h v=%b busy=%b want c=%h v=1 busy=0",
                      bus.c_out, bus.valid_out, bus.busy, exp_c);
    end
    tick();
  endtask

  task automatic test_flush_ignored();
    logic [1:0][31:0] exp_c;
    exp_c[0] = 32'd14;
    exp_c[1] = 32'd21;
    set_in(16'd2, 16'd3, 16'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL flush_pass_mode got c=%h v=%b busy=%b want c=%h v=1 busy=0",
                      bus.c_out, bus.valid_out, bus.busy, exp_c);
    end
    set_in(16'd1, 16'd1, 16'd1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(16'd5, 16'd5, 16'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(16'd1, 16'd1, 16'd1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    total++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL flush_invalid got v=%b busy=%b want v=0 busy=1", bus.valid_out, bus.busy);
    end
    tick();
    exp_c[0] = 32'd2;
    exp_c[1] = 32'd2;
    total++;
    if (bus.c_out !== exp_c || bus.valid_out !== 1'b1) begin
      bad++; $display("FAIL flush_invalid_result got c=%h v=%b want c=%h v=1", bus.c_out, bus.valid_out, exp_c);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pass();
    test_accum();
    test_wrap();
    test_stall();
    test_reset_abort();
    test_interleave();
    test_flush_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
